// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the compile-time digit-count / width-check helpers.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } cmp_state_t;

    // Returns 0 for an illegal WIDTH/DIGIT pairing so misconfiguration is obvious.
    function automatic int cmp_digit_count(input int width, input int digit);
        if (digit <= 0 || (width % digit) != 0) begin
            return 0;
        end
        return width / digit;
    endfunction

    function automatic int cmp_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational single-digit stage of the MSB-first magnitude comparison.
// Once the running eq flag has dropped, the incoming result passes through untouched.
module digit_comparator #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             eq_prev,
    input  logic             gt_prev,
    output logic             eq,
    output logic             gt
);

    assign eq = eq_prev & (a_d == b_d);
    assign gt = gt_prev | (eq_prev & (a_d > b_d));

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial unsigned magnitude comparator with cascade inputs.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first mismatching digit.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             eq_in,
    input  logic             gt_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int N     = cmp_digit_count(WIDTH, DIGIT);
    localparam int CNT_W = cmp_cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

    cmp_state_t       r_state;
    cmp_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_eq_run;
    logic             r_gt_run;
    logic [CNT_W-1:0] r_cnt;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic [DIGIT-1:0] w_a_dig [N];
    logic [DIGIT-1:0] w_b_dig [N];
    logic [DIGIT-1:0] w_a_sel;
    logic [DIGIT-1:0] w_b_sel;
    logic             w_eq;
    logic             w_gt;
    logic             w_last;

    // Slice the latched operands into digits; the down-counter picks one per cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_digit
            assign w_a_dig[gi] = r_a[gi*DIGIT +: DIGIT];
            assign w_b_dig[gi] = r_b[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign w_a_sel = w_a_dig[r_cnt];
    assign w_b_sel = w_b_dig[r_cnt];

    digit_comparator #(
        .DIGIT   (DIGIT)
    ) u_digit (
        .a_d     (w_a_sel),
        .b_d     (w_b_sel),
        .eq_prev (r_eq_run),
        .gt_prev (r_gt_run),
        .eq      (w_eq),
        .gt      (w_gt)
    );

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign w_last = (r_cnt == '0) || !w_eq;
`else
    assign w_last = (r_cnt == '0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = eq_in ? ST_COMPARE : ST_DONE;
                end
            end
            ST_COMPARE: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    // Result registers only move on the edge that enters DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_eq_run <= 1'b1;
            r_gt_run <= 1'b0;
            r_cnt    <= '0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_eq_run <= 1'b1;
                        r_gt_run <= 1'b0;
                        r_cnt    <= CNT_LOAD;
                        if (!eq_in) begin
                            r_eq <= 1'b0;
                            r_gt <= gt_in;
                            r_lt <= !gt_in;
                        end
                    end
                end
                ST_COMPARE: begin
                    r_eq_run <= w_eq;
                    r_gt_run <= w_gt;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_eq <= w_eq;
                        r_gt <= w_gt;
                        r_lt <= !w_eq & !w_gt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eq = r_eq;
    assign gt = r_gt;
    assign lt = r_lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Randomized and directed bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2).
module tb_seq_magnitude_comparator;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         eq_in;
    logic         gt_in;
    logic         busy;
    logic         done;
    logic         eq;
    logic         gt;
    logic         lt;

    int n_vec = 0;
    int n_err = 0;
    logic m_eq = 1'b0;
    logic m_gt = 1'b0;
    logic m_lt = 1'b0;

    seq_magnitude_comparator #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .eq_in (eq_in),
        .gt_in (gt_in),
        .busy  (busy),
        .done  (done),
        .eq    (eq),
        .gt    (gt),
        .lt    (lt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble();
        a     = W'($urandom);
        b     = W'($urandom);
        eq_in = 1'($urandom);
        gt_in = 1'($urandom);
    endtask

    // Start in the current cycle (cycle 0); smask[c] drives start in cycle c.
    // Returns positioned in the first IDLE cycle after DONE.
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic te, input logic tg,
                           input logic [15:0] smask, input string tag);
        int  j;
        int  exp_lat;
        int  got_lat;
        int  cyc;
        logic exp_eq;
        logic exp_gt;
        logic exp_lt;

        j = 0;
        for (int d = N - 1; d >= 0; d--) begin
            if (j == 0 && ((ta >> (d * D)) & 3) != ((tb >> (d * D)) & 3)) begin
                j = N - d;
            end
        end
        if (!te)                   exp_lat = 1;
        else if (EARLY && j != 0)  exp_lat = j + 1;
        else                       exp_lat = N + 1;
        exp_eq = te && (ta == tb);
        exp_gt = te ? (ta > tb) : tg;
        exp_lt = te ? (ta < tb) : !tg;

        start = 1'b1;
        a = ta; b = tb; eq_in = te; gt_in = tg;
        step();
        cyc = 1;
        got_lat = 0;
        while (got_lat == 0 && cyc <= N + 3) begin
            start = smask[cyc];
            scramble();
            if (cyc == 1) begin
                chk({tag, ".busy"}, busy, 1'b1);
                if (exp_lat > 1) begin
                    chk({tag, ".hold"}, {eq, gt, lt}, {m_eq, m_gt, m_lt});
                end
            end
            if (done) begin
                got_lat = cyc;
            end else begin
                step();
                cyc++;
            end
        end
        chk({tag, ".latency"}, got_lat, exp_lat);
        chk({tag, ".eqgtlt"}, {eq, gt, lt}, {exp_eq, exp_gt, exp_lt});
        step();
        start = 1'b0;
        chk({tag, ".postdone"}, {done, busy}, 2'b00);
        m_eq = exp_eq; m_gt = exp_gt; m_lt = exp_lt;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         re;

        // Start coincident with reset must be discarded.
        reset = 1'b1; start = 1'b1;
        a = 8'h55; b = 8'h11; eq_in = 1'b1; gt_in = 1'b0;
        step();
        step();
        chk("reset.outputs", {busy, done, eq, gt, lt}, 5'b0);
        reset = 1'b0; start = 1'b0;
        step();
        chk("reset.start_dropped", {busy, done}, 2'b00);

        run_txn(8'hA5, 8'hA5, 1'b1, 1'b0, 16'h0, "equal");
        run_txn(8'h80, 8'h7F, 1'b1, 1'b0, 16'h0, "gt_msb");
        run_txn(8'h12, 8'h13, 1'b1, 1'b1, 16'h0, "lt_lsb");
        run_txn(8'h00, 8'hFF, 1'b0, 1'b1, 16'h0, "cascade_gt");
        run_txn(8'hFF, 8'h00, 1'b0, 1'b0, 16'h0, "cascade_lt");
        run_txn(8'h3C, 8'h3C, 1'b1, 1'b0, 16'h0024, "busy_start");
        run_txn(8'h01, 8'h00, 1'b1, 1'b0, 16'h0, "back_to_back");

        // Reset in cycle 3 aborts the comparison without a done pulse.
        start = 1'b1; a = 8'h12; b = 8'h13; eq_in = 1'b1; gt_in = 1'b0;
        step();
        start = 1'b0;
        chk("abort.c1", done, 1'b0);
        step();
        chk("abort.c2", done, 1'b0);
        step();
        chk("abort.c3", done, 1'b0);
        reset = 1'b1;
        step();
        chk("abort.c4", {busy, done, eq, gt, lt}, 5'b0);
        reset = 1'b0;
        step();
        m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0;

        for (int t = 0; t < 150; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
                default: rb = W'($urandom);
            endcase
            re = ($urandom_range(0, 7) != 0);
            run_txn(ra, rb, re, 1'($urandom), 16'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_magnitude_comparator.md
SEQ_MAGNITUDE_COMPARATOR -- requirements
Module: seq_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 2: bits compared per cycle; WIDTH mod DIGIT == 0; N = WIDTH/DIGIT.
REQ-003 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 a  in  WIDTH  operand A, unsigned.
REQ-007 b  in  WIDTH  operand B, unsigned.
REQ-008 eq_in  in  1  cascade: higher-order word equal.
REQ-009 gt_in  in  1  cascade: higher-order word greater.
REQ-010 busy  out  1  high whenever state != IDLE.
REQ-011 done  out  1  one-cycle result-valid pulse.
REQ-012 eq, gt, lt  out  1 each  registered result; one-hot after first completion.

Function
REQ-013 FSM SHALL have states IDLE, COMPARE, DONE; DONE always returns to IDLE next cycle.
REQ-014 start high in IDLE in cycle k SHALL latch a, b, eq_in, gt_in and set running eq=1, gt=0.
REQ-015 eq_in=0 at start SHALL skip COMPARE: DONE in cycle k+1, gt=gt_in, lt=!gt_in, eq=0; a/b ignored.
REQ-016 eq_in=1 SHALL take priority; gt_in ignored in that case.
REQ-017 COMPARE SHALL process digit i (MSB-first, i=1..N) in cycle k+i; while running eq=1, digit A>B sets gt=1,eq=0; A<B sets eq=0,gt=0; once eq=0 later digits SHALL not change result.
REQ-018 Without early exit, DONE SHALL occur in cycle k+N+1 and done SHALL be high only in that cycle.
REQ-019 eq/gt/lt SHALL update only on entry to DONE and hold until the next DONE entry; lt = !eq & !gt.
REQ-020 start while busy (COMPARE or DONE) SHALL be ignored, no queuing; minimum start-to-start spacing N+2 cycles.
REQ-021 Latched operands SHALL be immune to a/b/eq_in/gt_in changes after cycle k.

Reset
REQ-022 reset high at any edge SHALL force IDLE, busy=0, done=0, eq=0, gt=0, lt=0, overriding start and aborting any comparison without a done pulse.
REQ-023 start coincident with reset SHALL be discarded.

Configuration
REQ-024 Macro SEQ_CMP_EARLY_EXIT_EN defined: first mismatching digit in cycle k+j SHALL cause DONE in cycle k+j+1; equal operands still DONE at k+N+1.
REQ-025 Macro undefined: COMPARE SHALL always run all N cycles; results identical in both builds, only latency differs.

Structure
REQ-026 Shared package cmp_pkg SHALL hold the FSM state enum and the digit-count/width-check constant function.
REQ-027 Sub-module digit_comparator SHALL be a combinational DIGIT-wide stage (a_d, b_d, eq_prev, gt_prev -> eq, gt), instantiated once.
REQ-028 Digit select SHALL use a log2(N)-bit down-counter loaded with N-1 at start.

Verification (WIDTH=8, DIGIT=2, N=4, start in cycle 0)
REQ-029 a=8'hA5, b=8'hA5, eq_in=1 -> done in cycle 5, eq=1, gt=0, lt=0.
REQ-030 a=8'h80, b=8'h7F, eq_in=1 -> gt=1; done cycle 2 with SEQ_CMP_EARLY_EXIT_EN, cycle 5 without.
REQ-031 a=8'h12, b=8'h13 -> lt=1, done cycle 5 in both builds.
REQ-032 eq_in=0, gt_in=1, a=8'h00, b=8'hFF -> done cycle 1, gt=1.
REQ-033 start again in cycles 2 and 5 -> both ignored, single done pulse in cycle 5; start in cycle 6 accepted.
REQ-034 reset high in cycle 3 mid-COMPARE -> no done pulse, all outputs 0 from cycle 4, busy=0.
